// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IF/ID payload width is fixed by FETCH_N; instantiate fetch with N == FETCH_N.
package fetch_pkg;

  localparam int FETCH_N = 24;

  // Architectural NOP encoding; deliberately non-zero so a bubble is
  // distinguishable from fetched zero words.
  localparam logic [FETCH_N-1:0] NOP_INSTR = 24'hE00000;

  typedef struct packed {
    logic [FETCH_N-1:0] instr;
    logic [FETCH_N-1:0] pc_plus8;
    logic               valid;
  } if_id_t;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BRANCH_E,
    PC_WB,
    PC_HOLD
  } pc_src_e;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus8: '0, valid: 1'b0};

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard controls, redirects, instruction memory and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the FetchCountF/BubbleCountF performance counter outputs.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int N = FETCH_N
);

  logic         StallF;
  logic         StallD;
  logic         FlushD;
  logic         BranchTakenE;
  logic [N-1:0] ALUResultE;
  logic         PCSrcW;
  logic [N-1:0] ResultW;
  logic [N-1:0] InstrF;
  logic         InstrValidF;
  logic [N-1:0] PCF;
  logic [N-1:0] InstrD;
  logic [N-1:0] PCPlus8D;
  logic         ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  FetchCountF;
  logic [31:0]  BubbleCountF;
`endif

  // Core / hazard-unit / memory side.
  modport master (
    output StallF, StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW,
           InstrF, InstrValidF,
    input  PCF, InstrD, PCPlus8D, ValidD
`ifdef FETCH_PERF_CNT_EN
    , input FetchCountF, BubbleCountF
`endif
  );

  // Fetch stage side.
  modport slave (
    input  StallF, StallD, FlushD, BranchTakenE, ALUResultE, PCSrcW, ResultW,
           InstrF, InstrValidF,
    output PCF, InstrD, PCPlus8D, ValidD
`ifdef FETCH_PERF_CNT_EN
    , output FetchCountF, BubbleCountF
`endif
  );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: flush > stall > memory-wait bubble > load.
// Asynchronous reset loads a bubble.
module fetch_if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_flush,
  input  logic   i_stall,
  input  logic   i_instr_valid,
  input  if_id_t i_fetched,
  output if_id_t o_q
);

  if_id_t r_q;
  if_id_t w_next;

  always_comb begin
    w_next = r_q;
    if (i_flush) begin
      w_next = IF_ID_BUBBLE;
    end else if (i_stall) begin
      w_next = r_q;
    end else if (!i_instr_valid) begin
      w_next = IF_ID_BUBBLE;
    end else begin
      w_next = i_fetched;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= IF_ID_BUBBLE;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, next-PC redirect mux and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/bubble counters.
module fetch
  import fetch_pkg::*;
#(
  parameter int          N        = FETCH_N,
  parameter int unsigned PC_STEP  = 1,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic  clk,
  input  logic  rst,
  fetch_if.slave bus
);

  localparam logic [N-1:0] STEP1 = N'(PC_STEP);
  localparam logic [N-1:0] STEP2 = N'(2 * PC_STEP);

  pc_src_e      w_pc_src;
  logic [N-1:0] w_pc_next;
  logic [N-1:0] r_pc;
  if_id_t       w_fetched;
  if_id_t       w_if_id;

  // Redirects win over every hold so a resolved branch is never lost to a stall.
  always_comb begin
    w_pc_src = PC_SEQ;
    if (bus.BranchTakenE) begin
      w_pc_src = PC_BRANCH_E;
    end else if (bus.PCSrcW) begin
      w_pc_src = PC_WB;
    end else if (bus.StallF || !bus.InstrValidF) begin
      w_pc_src = PC_HOLD;
    end
  end

  always_comb begin
    w_pc_next = r_pc + STEP1;
    case (w_pc_src)
      PC_BRANCH_E: w_pc_next = bus.ALUResultE;
      PC_WB:       w_pc_next = bus.ResultW;
      PC_HOLD:     w_pc_next = r_pc;
      default:     w_pc_next = r_pc + STEP1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign w_fetched = '{instr: bus.InstrF, pc_plus8: r_pc + STEP2, valid: 1'b1};

  fetch_if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (bus.FlushD),
    .i_stall      (bus.StallD),
    .i_instr_valid(bus.InstrValidF),
    .i_fetched    (w_fetched),
    .o_q          (w_if_id)
  );

  assign bus.PCF      = r_pc;
  assign bus.InstrD   = w_if_id.instr;
  assign bus.PCPlus8D = w_if_id.pc_plus8;
  assign bus.ValidD   = w_if_id.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_load;
  logic        w_load_valid;

  // A stall hold is not a load; flush and memory-wait loads count as bubbles.
  assign w_load       = bus.FlushD || !bus.StallD;
  assign w_load_valid = !bus.FlushD && bus.InstrValidF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (w_load) begin
      if (w_load_valid) begin
        r_fetch_cnt <= sat_inc32(r_fetch_cnt);
      end else begin
        r_bubble_cnt <= sat_inc32(r_bubble_cnt);
      end
    end
  end

  assign bus.FetchCountF  = r_fetch_cnt;
  assign bus.BubbleCountF = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage.
module tb_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  fetch_if u_if ();

  fetch dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mem(input logic [23:0] a);
    return 24'hC30000 ^ a;
  endfunction

  assign u_if.InstrF = mem(u_if.PCF);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    u_if.StallF       = 1'b0;
    u_if.StallD       = 1'b0;
    u_if.FlushD       = 1'b0;
    u_if.BranchTakenE = 1'b0;
    u_if.ALUResultE   = '0;
    u_if.PCSrcW       = 1'b0;
    u_if.ResultW      = '0;
    u_if.InstrValidF  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_ctrl();
    repeat (2) step();
    vectors++; if (u_if.PCF !== 24'h0) begin errors++; $display("FAIL reset_pcf: got %h want %h", u_if.PCF, 24'h0); end
    vectors++; if (u_if.InstrD !== NOP_INSTR) begin errors++; $display("FAIL reset_instrd: got %h want %h", u_if.InstrD, NOP_INSTR); end
    vectors++; if (u_if.PCPlus8D !== 24'h0) begin errors++; $display("FAIL reset_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h0); end
    vectors++; if (u_if.ValidD !== 1'b0) begin errors++; $display("FAIL reset_validd: got %b want 0", u_if.ValidD); end
    rst = 1'b0;
    #1;
    vectors++; if (u_if.PCF !== 24'h0) begin errors++; $display("FAIL first_pcf: got %h want %h", u_if.PCF, 24'h0); end
    vectors++; if (u_if.ValidD !== 1'b0) begin errors++; $display("FAIL first_validd: got %b want 0", u_if.ValidD); end
    for (int k = 1; k <= 3; k++) begin
      logic [23:0] pc_exp;
      pc_exp = 24'(k);
      step();
      vectors++; if (u_if.PCF !== pc_exp) begin errors++; $display("FAIL seq_pcf[%0d]: got %h want %h", k, u_if.PCF, pc_exp); end
      vectors++; if (u_if.InstrD !== mem(pc_exp - 24'd1)) begin errors++; $display("FAIL seq_instrd[%0d]: got %h want %h", k, u_if.InstrD, mem(pc_exp - 24'd1)); end
      vectors++; if (u_if.PCPlus8D !== pc_exp + 24'd1) begin errors++; $display("FAIL seq_pcplus8d[%0d]: got %h want %h", k, u_if.PCPlus8D, pc_exp + 24'd1); end
      vectors++; if (u_if.ValidD !== 1'b1) begin errors++; $display("FAIL seq_validd[%0d]: got %b want 1", k, u_if.ValidD); end
    end
  endtask

  task automatic test_stall();
    repeat (2) step();
    vectors++; if (u_if.PCF !== 24'h5) begin errors++; $display("FAIL pre_stall_pcf: got %h want %h", u_if.PCF, 24'h5); end
    u_if.StallF = 1'b1;
    u_if.StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (u_if.PCF !== 24'h5) begin errors++; $display("FAIL stall_pcf[%0d]: got %h want %h", k, u_if.PCF, 24'h5); end
      vectors++; if (u_if.InstrD !== mem(24'h4)) begin errors++; $display("FAIL stall_instrd[%0d]: got %h want %h", k, u_if.InstrD, mem(24'h4)); end
      vectors++; if (u_if.PCPlus8D !== 24'h6) begin errors++; $display("FAIL stall_pcplus8d[%0d]: got %h want %h", k, u_if.PCPlus8D, 24'h6); end
    end
    clear_ctrl();
    step();
    vectors++; if (u_if.PCF !== 24'h6) begin errors++; $display("FAIL unstall_pcf: got %h want %h", u_if.PCF, 24'h6); end
    vectors++; if (u_if.InstrD !== mem(24'h5)) begin errors++; $display("FAIL unstall_instrd: got %h want %h", u_if.InstrD, mem(24'h5)); end
    vectors++; if (u_if.PCPlus8D !== 24'h7) begin errors++; $display("FAIL unstall_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h7); end
  endtask

  task automatic test_redirect();
    u_if.BranchTakenE = 1'b1;
    u_if.ALUResultE   = 24'h40;
    u_if.PCSrcW       = 1'b1;
    u_if.ResultW      = 24'h80;
    u_if.StallF       = 1'b1;
    step();
    vectors++; if (u_if.PCF !== 24'h40) begin errors++; $display("FAIL branch_pcf: got %h want %h", u_if.PCF, 24'h40); end
    vectors++; if (u_if.InstrD !== mem(24'h6)) begin errors++; $display("FAIL branch_instrd: got %h want %h", u_if.InstrD, mem(24'h6)); end
    vectors++; if (u_if.PCPlus8D !== 24'h8) begin errors++; $display("FAIL branch_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h8); end
    u_if.BranchTakenE = 1'b0;
    u_if.StallF       = 1'b0;
    step();
    vectors++; if (u_if.PCF !== 24'h80) begin errors++; $display("FAIL wb_pcf: got %h want %h", u_if.PCF, 24'h80); end
    vectors++; if (u_if.InstrD !== mem(24'h40)) begin errors++; $display("FAIL wb_instrd: got %h want %h", u_if.InstrD, mem(24'h40)); end
    u_if.PCSrcW       = 1'b0;
    u_if.BranchTakenE = 1'b1;
    u_if.ALUResultE   = 24'h10;
    u_if.FlushD       = 1'b1;
    u_if.StallD       = 1'b1;
    u_if.StallF       = 1'b1;
    step();
    vectors++; if (u_if.PCF !== 24'h10) begin errors++; $display("FAIL flush_pcf: got %h want %h", u_if.PCF, 24'h10); end
    vectors++; if (u_if.ValidD !== 1'b0) begin errors++; $display("FAIL flush_validd: got %b want 0", u_if.ValidD); end
    vectors++; if (u_if.InstrD !== NOP_INSTR) begin errors++; $display("FAIL flush_instrd: got %h want %h", u_if.InstrD, NOP_INSTR); end
    vectors++; if (u_if.PCPlus8D !== 24'h0) begin errors++; $display("FAIL flush_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h0); end
    clear_ctrl();
  endtask

  task automatic test_mem_wait();
    u_if.InstrValidF = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++; if (u_if.PCF !== 24'h10) begin errors++; $display("FAIL wait_pcf[%0d]: got %h want %h", k, u_if.PCF, 24'h10); end
      vectors++; if (u_if.ValidD !== 1'b0) begin errors++; $display("FAIL wait_validd[%0d]: got %b want 0", k, u_if.ValidD); end
      vectors++; if (u_if.InstrD !== NOP_INSTR) begin errors++; $display("FAIL wait_instrd[%0d]: got %h want %h", k, u_if.InstrD, NOP_INSTR); end
    end
    u_if.InstrValidF = 1'b1;
    step();
    vectors++; if (u_if.PCF !== 24'h11) begin errors++; $display("FAIL ready_pcf: got %h want %h", u_if.PCF, 24'h11); end
    vectors++; if (u_if.InstrD !== mem(24'h10)) begin errors++; $display("FAIL ready_instrd: got %h want %h", u_if.InstrD, mem(24'h10)); end
    vectors++; if (u_if.PCPlus8D !== 24'h12) begin errors++; $display("FAIL ready_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h12); end
    vectors++; if (u_if.ValidD !== 1'b1) begin errors++; $display("FAIL ready_validd: got %b want 1", u_if.ValidD); end
  endtask

  task automatic test_wrap();
    u_if.PCSrcW  = 1'b1;
    u_if.ResultW = 24'hFFFFFE;
    step();
    vectors++; if (u_if.PCF !== 24'hFFFFFE) begin errors++; $display("FAIL wrap_load_pcf: got %h want %h", u_if.PCF, 24'hFFFFFE); end
    clear_ctrl();
    step();
    vectors++; if (u_if.PCF !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_top_pcf: got %h want %h", u_if.PCF, 24'hFFFFFF); end
    vectors++; if (u_if.PCPlus8D !== 24'h000000) begin errors++; $display("FAIL wrap_fffffe_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h0); end
    step();
    vectors++; if (u_if.PCF !== 24'h000000) begin errors++; $display("FAIL wrap_zero_pcf: got %h want %h", u_if.PCF, 24'h0); end
    vectors++; if (u_if.InstrD !== mem(24'hFFFFFF)) begin errors++; $display("FAIL wrap_instrd: got %h want %h", u_if.InstrD, mem(24'hFFFFFF)); end
    vectors++; if (u_if.PCPlus8D !== 24'h000001) begin errors++; $display("FAIL wrap_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h1); end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    u_if.BranchTakenE = 1'b1;
    u_if.ALUResultE   = 24'h33;
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (u_if.PCF !== 24'h0) begin errors++; $display("FAIL async_pcf: got %h want %h", u_if.PCF, 24'h0); end
    vectors++; if (u_if.InstrD !== NOP_INSTR) begin errors++; $display("FAIL async_instrd: got %h want %h", u_if.InstrD, NOP_INSTR); end
    vectors++; if (u_if.PCPlus8D !== 24'h0) begin errors++; $display("FAIL async_pcplus8d: got %h want %h", u_if.PCPlus8D, 24'h0); end
    vectors++; if (u_if.ValidD !== 1'b0) begin errors++; $display("FAIL async_validd: got %b want 0", u_if.ValidD); end
    step();
    vectors++; if (u_if.PCF !== 24'h0) begin errors++; $display("FAIL held_reset_pcf: got %h want %h", u_if.PCF, 24'h0); end
    clear_ctrl();
    rst = 1'b0;
    step();
    vectors++; if (u_if.PCF !== 24'h1) begin errors++; $display("FAIL post_reset_pcf: got %h want %h", u_if.PCF, 24'h1); end
    vectors++; if (u_if.InstrD !== mem(24'h0)) begin errors++; $display("FAIL post_reset_instrd: got %h want %h", u_if.InstrD, mem(24'h0)); end
    vectors++; if (u_if.ValidD !== 1'b1) begin errors++; $display("FAIL post_reset_validd: got %b want 1", u_if.ValidD); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    clear_ctrl();
    rst = 1'b1;
    #1;
    vectors++; if (u_if.FetchCountF !== 32'd0) begin errors++; $display("FAIL cnt_reset_fetch: got %0d want 0", u_if.FetchCountF); end
    vectors++; if (u_if.BubbleCountF !== 32'd0) begin errors++; $display("FAIL cnt_reset_bubble: got %0d want 0", u_if.BubbleCountF); end
    step();
    rst = 1'b0;
    repeat (10) step();
    u_if.FlushD = 1'b1;
    repeat (3) step();
    u_if.FlushD = 1'b0;
    u_if.StallF = 1'b1;
    u_if.StallD = 1'b1;
    repeat (2) step();
    clear_ctrl();
    vectors++; if (u_if.FetchCountF !== 32'd10) begin errors++; $display("FAIL cnt_fetch: got %0d want 10", u_if.FetchCountF); end
    vectors++; if (u_if.BubbleCountF !== 32'd3) begin errors++; $display("FAIL cnt_bubble: got %0d want 3", u_if.BubbleCountF); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_mem_wait();
    test_wrap();
    test_async_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
